// File: rtl/fu_wb_arbiter_if.sv
// Pipeline squash request: the producer raises valid to flush downstream buffered state.
interface squash_if;
  logic valid;
  modport master (output valid);
  modport slave  (input  valid);
endinterface

// File: rtl/fu_wb_arbiter.sv
// Writeback arbiter: one small result FIFO per functional unit, drained round-robin
// onto a single writeback port with valid/ready handshake and pipeline squash.
package fu_wb_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  id;
    logic [5:0]  prd;
    logic [31:0] rdval;
  } fu_output_t;
endpackage

module fu_wb_arbiter
  import fu_wb_pkg::*;
#(
  parameter int NFU   = 4,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  fu_output_t [NFU-1:0] fuoutput_i,
  input  logic [NFU-1:0]       fuoutput_i_valid,
  output logic [NFU-1:0]       fu_full_o,
  output fu_output_t           wb_o,
  output logic                 wb_o_valid,
  input  logic                 wb_o_ready,
  squash_if.slave              squash_io,
  output logic                 overflow_o
);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int RW  = (NFU > 1) ? $clog2(NFU) : 1;
  localparam int RW1 = RW + 1;

  fu_output_t    mem_q   [NFU][DEPTH];
  fu_output_t    mem_d   [NFU][DEPTH];
  logic [PW-1:0] wptr_q  [NFU];
  logic [PW-1:0] wptr_d  [NFU];
  logic [PW-1:0] rptr_q  [NFU];
  logic [PW-1:0] rptr_d  [NFU];
  logic [CW-1:0] count_q [NFU];
  logic [CW-1:0] count_d [NFU];
  logic [RW-1:0] rr_ptr_q, rr_ptr_d;
  logic [RW-1:0] lock_grant_q, lock_grant_d;
  logic          lock_q, lock_d;
  logic          overflow_q, overflow_d;

  logic [NFU-1:0] nonempty;
  logic [NFU-1:0] full;
  logic [NFU-1:0] push;
  logic [RW-1:0]  rr_grant;
  logic [RW-1:0]  grant;
  logic           any_valid;
  logic           pop;
  logic           squash;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (DEPTH == 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int k = 0; k < NFU; k++) begin
      nonempty[k] = (count_q[k] != '0);
      full[k]     = (count_q[k] == CW'(DEPTH));
    end
  end

  // First non-empty FIFO at or after rr_ptr, wrapping around the source list.
  always_comb begin
    logic [RW1-1:0] idx;
    logic           hit;
    idx      = '0;
    hit      = 1'b0;
    rr_grant = rr_ptr_q;
    for (int i = 0; i < NFU; i++) begin
      idx = {1'b0, rr_ptr_q} + RW1'(i);
      if (idx >= RW1'(NFU)) idx = idx - RW1'(NFU);
      if (!hit && nonempty[idx[RW-1:0]]) begin
        hit      = 1'b1;
        rr_grant = idx[RW-1:0];
      end
    end
  end

  // A stalled grant is latched so newly filled sources cannot steal the port mid-offer.
  assign grant     = lock_q ? lock_grant_q : rr_grant;
  assign any_valid = |nonempty;
  assign squash    = squash_io.valid;
  assign pop       = any_valid && wb_o_ready && !squash;

  assign wb_o_valid = rstn && any_valid;
  assign wb_o       = wb_o_valid ? mem_q[grant][rptr_q[grant]] : '0;
  assign fu_full_o  = rstn ? full : '0;
  assign overflow_o = rstn && overflow_q;

  always_comb begin
    logic pop_k;
    pop_k        = 1'b0;
    mem_d        = mem_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    rr_ptr_d     = rr_ptr_q;
    overflow_d   = overflow_q;
    lock_d       = 1'b0;
    lock_grant_d = grant;
    push         = '0;
    if (squash) begin
      for (int k = 0; k < NFU; k++) begin
        wptr_d[k]  = '0;
        rptr_d[k]  = '0;
        count_d[k] = '0;
      end
    end else begin
      lock_d = any_valid && !wb_o_ready;
      if (pop) begin
        rptr_d[grant] = ptr_inc(rptr_q[grant]);
        rr_ptr_d      = (grant == RW'(NFU - 1)) ? '0 : grant + 1'b1;
      end
      for (int k = 0; k < NFU; k++) begin
        pop_k = pop && (grant == RW'(k));
        if (fuoutput_i_valid[k]) begin
          if (!full[k] || pop_k) begin
            push[k]              = 1'b1;
            mem_d[k][wptr_q[k]]  = fuoutput_i[k];
            wptr_d[k]            = ptr_inc(wptr_q[k]);
          end else begin
            overflow_d = 1'b1;
          end
        end
        count_d[k] = count_q[k] + CW'(push[k]) - CW'(pop_k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < NFU; k++) begin
        wptr_q[k]  <= '0;
        rptr_q[k]  <= '0;
        count_q[k] <= '0;
      end
      rr_ptr_q     <= '0;
      lock_q       <= 1'b0;
      lock_grant_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      rr_ptr_q     <= rr_ptr_d;
      lock_q       <= lock_d;
      lock_grant_q <= lock_grant_d;
      overflow_q   <= overflow_d;
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule
